// File: rtl/mem_port_responder.sv
// Toggle-handshake memory port with strict priority over a free-running background
// reader. Every access is a one-cycle strobe, then a countdown to the fixed read latency.
module mem_port_responder #(
   parameter int AW     = 23,
   parameter int RD_LAT = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          port_req,
   output logic          port_ack,
   input  logic [AW-1:0] port_a,
   input  logic [1:0]    port_ds,
   input  logic          port_we,
   input  logic [15:0]   port_d,
   output logic [15:0]   port_q,
   input  logic [AW-1:0] rd_addr,
   output logic [15:0]   rd_q,
   output logic          rd_valid,
   output logic          mem_cs,
   output logic          mem_we,
   output logic [1:0]    mem_be,
   output logic [AW-1:0] mem_addr,
   output logic [15:0]   mem_wdata,
   input  logic [15:0]   mem_rdata
);

   typedef enum logic [1:0] {IDLE, PORT_ACC, BG_ACC} state_t;

   localparam logic [2:0] LAT = 3'(RD_LAT);

   state_t        state_q, state_d;
   logic [2:0]    cnt_q, cnt_d;
   logic          port_ack_q, port_ack_d;
   logic [15:0]   port_q_q, port_q_d;
   logic [15:0]   rd_q_q, rd_q_d;
   logic          rd_valid_q, rd_valid_d;
   logic          mem_cs_q, mem_cs_d;
   logic          mem_we_q, mem_we_d;
   logic [1:0]    mem_be_q, mem_be_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [15:0]   mem_wdata_q, mem_wdata_d;
   logic          acc_we_q, acc_we_d;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      port_ack_d  = port_ack_q;
      port_q_d    = port_q_q;
      rd_q_d      = rd_q_q;
      rd_valid_d  = 1'b0;
      mem_cs_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_be_d    = mem_be_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      acc_we_d    = acc_we_q;

      case (state_q)
         IDLE: begin
            // Registered strobe: the latched fields are what the memory sees next cycle.
            cnt_d    = LAT;
            mem_cs_d = 1'b1;
            if (port_req != port_ack_q) begin
               state_d     = PORT_ACC;
               mem_we_d    = port_we;
               acc_we_d    = port_we;
               mem_be_d    = port_we ? port_ds : 2'b11;
               mem_addr_d  = port_a;
               mem_wdata_d = port_d;
            end else begin
               state_d    = BG_ACC;
               acc_we_d   = 1'b0;
               mem_be_d   = 2'b11;
               mem_addr_d = rd_addr;
            end
         end
         PORT_ACC, BG_ACC: begin
            if (cnt_q == 3'd0) begin
               state_d = IDLE;
               if (state_q == PORT_ACC) begin
                  port_ack_d = ~port_ack_q;
                  if (!acc_we_q) port_q_d = mem_rdata;
               end else begin
                  rd_q_d     = mem_rdata;
                  rd_valid_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         port_ack_q  <= 1'b0;
         port_q_q    <= '0;
         rd_q_q      <= '0;
         rd_valid_q  <= 1'b0;
         mem_cs_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_be_q    <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         acc_we_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         port_ack_q  <= port_ack_d;
         port_q_q    <= port_q_d;
         rd_q_q      <= rd_q_d;
         rd_valid_q  <= rd_valid_d;
         mem_cs_q    <= mem_cs_d;
         mem_we_q    <= mem_we_d;
         mem_be_q    <= mem_be_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         acc_we_q    <= acc_we_d;
      end
   end

   assign port_ack  = port_ack_q;
   assign port_q    = port_q_q;
   assign rd_q      = rd_q_q;
   assign rd_valid  = rd_valid_q;
   assign mem_cs    = mem_cs_q;
   assign mem_we    = mem_we_q;
   assign mem_be    = mem_be_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_responder.sv
// Bench for mem_port_responder: fixed-latency memory model, transaction-level
// reference image, table vectors plus reset, collision and back-to-back sequences.
module tb_mem_port_responder;

   localparam int AW      = 23;
   localparam int RD_LAT  = 2;
   localparam int LAT_MAX = 2 * (RD_LAT + 2);

   logic          clk = 1'b0;
   logic          reset;
   logic          port_req;
   logic          port_ack;
   logic [AW-1:0] port_a;
   logic [1:0]    port_ds;
   logic          port_we;
   logic [15:0]   port_d;
   logic [15:0]   port_q;
   logic [AW-1:0] rd_addr;
   logic [15:0]   rd_q;
   logic          rd_valid;
   logic          mem_cs;
   logic          mem_we;
   logic [1:0]    mem_be;
   logic [AW-1:0] mem_addr;
   logic [15:0]   mem_wdata;
   logic [15:0]   mem_rdata;

   always #5 clk = ~clk;

   mem_port_responder #(.AW(AW), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .reset(reset),
      .port_req(port_req), .port_ack(port_ack), .port_a(port_a), .port_ds(port_ds),
      .port_we(port_we), .port_d(port_d), .port_q(port_q),
      .rd_addr(rd_addr), .rd_q(rd_q), .rd_valid(rd_valid),
      .mem_cs(mem_cs), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // Unwritten words have fixed contents so reads are predictable.
   function automatic logic [15:0] init_val(input logic [AW-1:0] a);
      if (a == AW'(32'h7FFF)) return 16'h1234;
      if (a == AW'(32'h4000)) return 16'h5A5A;
      if (a == {AW{1'b1}})    return 16'hBEEF;
      return a[15:0] ^ 16'hC33C;
   endfunction

   logic [15:0] mem_img [int unsigned];
   logic [15:0] ref_img [int unsigned];
   logic [15:0] pipe [RD_LAT];

   function automatic logic [15:0] mem_get(input logic [AW-1:0] a);
      if (mem_img.exists(32'(a))) return mem_img[32'(a)];
      return init_val(a);
   endfunction

   function automatic logic [15:0] ref_get(input logic [AW-1:0] a);
      if (ref_img.exists(32'(a))) return ref_img[32'(a)];
      return init_val(a);
   endfunction

   function automatic void ref_write(input logic [AW-1:0] a, input logic [1:0] ds,
                                     input logic [15:0] d);
      logic [15:0] v;
      v = ref_get(a);
      if (ds[0]) v[7:0]  = d[7:0];
      if (ds[1]) v[15:8] = d[15:8];
      ref_img[32'(a)] = v;
   endfunction

   // Memory: data is valid exactly RD_LAT cycles after the strobe cycle, noise otherwise.
   always @(posedge clk) begin
      logic [15:0] cur;
      cur = 16'($urandom);
      if (mem_cs === 1'b1) begin
         if (mem_we === 1'b1) begin
            logic [15:0] w;
            w = mem_get(mem_addr);
            if (mem_be[0]) w[7:0]  = mem_wdata[7:0];
            if (mem_be[1]) w[15:8] = mem_wdata[15:8];
            mem_img[32'(mem_addr)] = w;
         end else begin
            cur = mem_get(mem_addr);
         end
      end
      pipe[0] <= cur;
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign mem_rdata = pipe[RD_LAT-1];

   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          rv_count = 0;
   logic        prev_rv = 1'b0;
   logic [15:0] bg_exp = 16'h5A5A;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
      if (rd_valid === 1'b1) begin
         rv_count++;
         chk("rd_valid_one_cycle", 32'(prev_rv), 32'd0);
         chk("rd_q", 32'(rd_q), 32'(bg_exp));
      end
      prev_rv = rd_valid;
   endtask

   task automatic chk_reset_vals();
      chk("rst_port_ack", 32'(port_ack), 32'd0);
      chk("rst_port_q", 32'(port_q), 32'd0);
      chk("rst_rd_q", 32'(rd_q), 32'd0);
      chk("rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("rst_mem_cs", 32'(mem_cs), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_be", 32'(mem_be), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
   endtask

   task automatic sync_idle();
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (rd_valid !== 1'b1 && n < 4 * (RD_LAT + 2));
      chk("bg_sync_rd_valid", 32'(rd_valid), 32'd1);
   endtask

   // Issues (tog=1) or follows a pending request until ack; exp_lat<=0 means only the bound.
   task automatic port_txn(input bit tog, input logic w, input logic [AW-1:0] a,
                           input logic [1:0] ds, input logic [15:0] d,
                           input logic [15:0] exp_q, input int exp_lat);
      logic [15:0] q0;
      logic        ack0;
      int          lat, cs_n;
      bit          done;
      q0 = port_q; ack0 = port_ack; lat = 0; cs_n = 0; done = 0;
      if (tog) begin
         port_a = a; port_ds = ds; port_we = w; port_d = d; port_req = ~port_req;
      end
      while (!done && lat < LAT_MAX + 2) begin
         tick();
         lat++;
         if (mem_cs === 1'b1) begin
            cs_n++;
            chk("acc_addr", 32'(mem_addr), 32'(a));
            chk("acc_we", 32'(mem_we), 32'(w));
            chk("acc_be", 32'(mem_be), w ? 32'(ds) : 32'h3);
            if (w) chk("acc_wdata", 32'(mem_wdata), 32'(d));
            port_a = ~a; port_ds = ~ds; port_we = ~w; port_d = ~d;
         end
         if (port_ack !== ack0) done = 1;
         else chk("port_q_held", 32'(port_q), 32'(q0));
      end
      chk("ack_returned", 32'(done), 32'd1);
      chk("acc_count", 32'(cs_n), 32'd1);
      chk("ack_bound", 32'(lat <= LAT_MAX), 32'd1);
      if (exp_lat > 0) chk("ack_latency", 32'(lat), 32'(exp_lat));
      if (w) begin
         chk("port_q_after_write", 32'(port_q), 32'(q0));
         ref_write(a, ds, d);
      end else begin
         chk("port_q_read", 32'(port_q), 32'(exp_q));
      end
   endtask

   typedef struct {
      logic          we;
      logic [AW-1:0] a;
      logic [1:0]    ds;
      logic [15:0]   d;
      logic [15:0]   exp_q;
   } vec_t;

   vec_t tbl [11];

   initial begin
      int          last, n, rv0, gap;
      logic        w;
      logic [AW-1:0] a;
      logic [1:0]  ds;
      logic [15:0] d;

      tbl[0]  = '{1'b1, AW'(32'h000100), 2'b01, 16'hABCD, 16'h0000};
      tbl[1]  = '{1'b0, AW'(32'h007FFF), 2'b00, 16'h0000, 16'h1234};
      tbl[2]  = '{1'b0, AW'(32'h000100), 2'b00, 16'h0000, 16'hC2CD};
      tbl[3]  = '{1'b1, AW'(32'h000100), 2'b10, 16'h77EE, 16'h0000};
      tbl[4]  = '{1'b1, AW'(32'h000100), 2'b00, 16'hFFFF, 16'h0000};
      tbl[5]  = '{1'b0, AW'(32'h000100), 2'b11, 16'h0000, 16'h77CD};
      tbl[6]  = '{1'b0, {AW{1'b1}},      2'b00, 16'h0000, 16'hBEEF};
      tbl[7]  = '{1'b1, {AW{1'b1}},      2'b11, 16'h0F0F, 16'h0000};
      tbl[8]  = '{1'b0, {AW{1'b1}},      2'b00, 16'h0000, 16'h0F0F};
      tbl[9]  = '{1'b1, AW'(32'h000100), 2'b11, 16'h1357, 16'h0000};
      tbl[10] = '{1'b0, AW'(32'h000100), 2'b00, 16'h0000, 16'h1357};

      reset = 1'b1; port_req = 1'b0; port_a = '0; port_ds = '0; port_we = 1'b0;
      port_d = '0; rd_addr = AW'(32'h4000);
      repeat (3) tick();
      chk_reset_vals();
      reset = 1'b0;

      // Background only: period and strobe fields.
      sync_idle();
      last = cyc;
      for (int k = 0; k < 4; k++) begin
         n = 0;
         do begin
            tick();
            n++;
            if (mem_cs === 1'b1) begin
               chk("bg_addr", 32'(mem_addr), 32'h4000);
               chk("bg_we", 32'(mem_we), 32'd0);
               chk("bg_be", 32'(mem_be), 32'h3);
            end
         end while (rd_valid !== 1'b1 && n < 4 * (RD_LAT + 2));
         chk("bg_period", 32'(cyc - last), 32'(RD_LAT + 2));
         last = cyc;
      end

      // Reset in the cycle after the strobe of a write, then the request is re-served.
      sync_idle();
      port_a = AW'(32'h200); port_ds = 2'b11; port_we = 1'b1; port_d = 16'h5555;
      port_req = 1'b1;
      tick();
      chk("rst_test_strobe", 32'(mem_cs), 32'd1);
      @(posedge clk);
      #1 reset = 1'b1;
      #1 chk_reset_vals();
      tick();
      tick();
      chk_reset_vals();
      reset = 1'b0;
      port_txn(1'b0, 1'b1, AW'(32'h200), 2'b11, 16'h5555, 16'h0000, RD_LAT + 2);

      for (int i = 0; i < 11; i++) begin
         sync_idle();
         port_txn(1'b1, tbl[i].we, tbl[i].a, tbl[i].ds, tbl[i].d, tbl[i].exp_q, RD_LAT + 2);
      end

      // Collision: request raised in the first background cycle.
      n = 0;
      do begin
         tick();
         n++;
      end while (mem_cs !== 1'b1 && n < 4 * (RD_LAT + 2));
      chk("coll_bg_strobe", 32'(mem_cs), 32'd1);
      rv0 = rv_count;
      port_txn(1'b1, 1'b0, AW'(32'h7FFF), 2'b00, 16'h0000, 16'h1234, 2 * RD_LAT + 3);
      chk("coll_bg_completed", 32'(rv_count - rv0), 32'd1);

      for (int i = 0; i < 80; i++) begin
         gap = $urandom_range(0, 2 * RD_LAT + 4);
         repeat (gap) tick();
         w  = 1'($urandom_range(0, 1));
         a  = AW'(32'h300 + $urandom_range(0, 7));
         ds = 2'($urandom);
         d  = 16'($urandom);
         port_txn(1'b1, w, a, ds, d, ref_get(a), 0);
      end

      // Back-to-back byte writes, each issued on the ack of the previous one.
      sync_idle();
      for (int i = 0; i < 256; i++) begin
         a  = AW'(32'h1000 + (i >> 1));
         ds = (i % 2 == 1) ? 2'b10 : 2'b01;
         d  = 16'($urandom);
         port_txn(1'b1, 1'b1, a, ds, d, 16'h0000, RD_LAT + 2);
      end
      for (int i = 0; i < 128; i++) begin
         a = AW'(32'h1000 + i);
         chk("image", 32'(mem_get(a)), 32'(ref_get(a)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1);
   end

endmodule

// File: doc/mem_port_responder.md
MEM_PORT_RESPONDER -- requirements
Module: mem_port_responder

Interface
REQ-001 The parameter list SHALL be: AW, default 23, word address width; RD_LAT, default 2, memory read latency in clocks (range 1..7).
REQ-002 The port list SHALL be as follows, one clock and one asynchronous active-high reset:
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high.
- port_req  in  1  toggle request; a request is pending when port_req != port_ack.
- port_ack  out  1  toggle acknowledge.
- port_a  in  AW  request word address.
- port_ds  in  2  byte strobes; [1] is the upper byte, [0] is the lower byte.
- port_we  in  1  1 = write, 0 = read.
- port_d  in  16  write data.
- port_q  out  16  read data of the last port read.
- rd_addr  in  AW  background read address.
- rd_q  out  16  background read data.
- rd_valid  out  1  one-cycle pulse when rd_q updates.
- mem_cs  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_be  out  2  memory byte enables.
- mem_addr  out  AW  memory address.
- mem_wdata  out  16  memory write data.
- mem_rdata  in  16  memory read data; valid exactly RD_LAT cycles after the mem_cs cycle.

Function
REQ-003 The FSM SHALL have three states:
- IDLE.
- PORT_ACC: service of a toggle request.
- BG_ACC: background read of rd_addr.
REQ-004 IDLE SHALL transition to PORT_ACC when a request is pending; otherwise it SHALL transition to BG_ACC.
REQ-005 The port SHALL have strict priority: a pending request SHALL never wait for more than one BG_ACC.
REQ-006 On leaving IDLE, the block SHALL latch address, strobes, we and data; later input changes SHALL NOT affect the access in progress.
REQ-007 Timing of an access:
- mem_cs SHALL be high for exactly one cycle, the first cycle of PORT_ACC or BG_ACC.
- The mem_addr/mem_we/mem_be/mem_wdata values driven in that cycle SHALL be the latched values.
- Outside that cycle, mem_cs and mem_we SHALL be 0.
REQ-008 A down-counter loaded with RD_LAT SHALL time each access. The access SHALL end in the cycle in which mem_rdata is valid, and the state SHALL be IDLE on the following cycle.
REQ-009 Port write: mem_we=1, mem_be=latched ds, mem_wdata=latched port_d. A write with ds=00 SHALL still run the full access, with be=00.
REQ-010 Port read: mem_we=0, mem_be=11. port_q SHALL capture mem_rdata at the end of the access.
REQ-011 port_ack SHALL toggle at the end of every PORT_ACC, on the same edge as the port_q update.
REQ-012 Latency: a request seen in IDLE at cycle t SHALL have mem_cs at t+1 and the ack toggle visible at t+RD_LAT+2.
REQ-013 BG_ACC: mem_we=0 and mem_be=11. At the end of the access, rd_q SHALL take mem_rdata and rd_valid SHALL pulse for one cycle.
REQ-014 The requester toggling port_req twice before ack is a protocol violation. The block SHALL NOT detect or queue it; the pending condition SHALL be re-evaluated only in IDLE.
REQ-015 A request arriving during BG_ACC SHALL be served immediately after that BG_ACC, with one IDLE cycle in between.
REQ-016 Address width SHALL be AW with no wrap logic; the all-ones address SHALL be a legal read target.

Reset
REQ-017 While reset is high, the block SHALL asynchronously force:
- state to IDLE;
- port_ack=0, port_q=0, rd_q=0, rd_valid=0;
- mem_cs=0, mem_we=0, mem_be=00, mem_addr=0, mem_wdata=0;
- the counter to 0.
REQ-018 Reset during an access SHALL abort it without toggling ack. The first cycle after release SHALL be IDLE.

Verification
REQ-019 Port write: RD_LAT=2, port_req 0->1, a=0x000100, ds=01, we=1, d=0xABCD -> mem_cs one cycle with be=01 and wdata=0xABCD; port_ack=1 four cycles after the request is seen.
REQ-020 Port read: memory model returns 0x1234 at a=0x7FFF, req toggles -> port_q=0x1234 on the same edge that port_ack toggles; mem_we=0, be=11.
REQ-021 Background: no requests, rd_addr=0x4000, model returns 0x5A5A -> rd_valid pulses every RD_LAT+2 cycles with rd_q=0x5A5A.
REQ-022 Collision: req toggles in the first BG_ACC cycle -> BG_ACC completes (rd_valid pulses), one IDLE cycle follows, then PORT_ACC; ack is delivered within 2*(RD_LAT+2) cycles.
REQ-023 Mid-access reset: assert reset in the cycle after mem_cs of a write -> port_ack=0, all outputs at reset values; after release, with req=1 and ack=0, the request is re-served.
REQ-024 Back-to-back: 256 byte writes with alternating ds=01/10, each toggled on ack -> every ack is returned, the memory model image matches, and no BG_ACC occurs between a pending request and its service.
